ic_refill_responder: RTL and testbench
======================================

# ic_refill_responder

Memory-side responder for instruction-cache line refills. It accepts one line request at a time, waits a fixed access latency, and returns the eight 32-bit words of the line as a beat stream the cache writes into its line buffer. It sits between the instruction cache and the backing word-addressed memory model. A side write port preloads program images and mirrors stores.

## Interface
Parameters:
- MEM_WORDS, 4096: backing-store depth in 32-bit words; must be a power of two.
- LATENCY, 4: cycles from request acceptance to first beat; legal range 1..15.
- LINE_WORDS, 8: words per line; fixed at 8, matching a 32-byte line.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low; clears state immediately.
- stall  in  1  pipeline stall; freezes beat delivery.
- req_valid  in  1  cache requests a line refill.
- req_addr  in  32  byte address inside the requested line.
- req_ready  out  1  responder idle and able to accept.
- resp_valid  out  1  beat valid this cycle.
- resp_data  out  32  beat word.
- resp_ofst  out  3  word offset of beat within the line.
- resp_last  out  1  final beat of the line.
- wr_en  in  1  backing-store write strobe.
- wr_addr  in  32  byte address of the write; bits [1:0] are ignored.
- wr_data  in  32  write word.

## Operation
- States: IDLE, WAIT, BURST.
- IDLE:
  - req_ready=1.
  - When req_valid=1 at posedge, latch line_base = req_addr[31:5], load lat_cnt=LATENCY-1, and go to WAIT.
- WAIT:
  - lat_cnt decrements every cycle, regardless of stall.
  - At lat_cnt==0, go to BURST with beat_cnt=0.
- BURST:
  - Each posedge with stall=0 registers one beat:
    - resp_valid=1.
    - resp_ofst = start_ofst + beat_cnt (mod 8).
    - resp_data = mem[{line_base, resp_ofst} mod MEM_WORDS].
    - beat_cnt increments.
  - While stall=1, the registered beat is held unchanged and no beat is consumed.
  - The beat with beat_cnt==7 drives resp_last=1. At the next unstalled edge, go to IDLE with resp_valid=0.
- start_ofst is 0 unless CRITICAL_WORD_FIRST_EN is defined (see Configuration).
- req_valid outside IDLE is ignored and not queued. The cache must re-present it.
- Address arithmetic:
  - Word index is a 30-bit byte-address shift, truncated to log2(MEM_WORDS) bits.
  - Out-of-range addresses alias modulo MEM_WORDS.
- Write port: mem written at posedge when wr_en=1, in any state.
  - If a write and a beat read hit the same word on the same edge, the beat returns the old data.
  - Later beats see the new data.
- Memory contents are not cleared by reset.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_data=0, resp_ofst=0, resp_last=0, state=IDLE.
- Reset asserted mid-WAIT or mid-BURST aborts the burst at once. No partial last beat is issued.
- With the request accepted at edge E0 and no stalls:
  - First beat is visible after edge E(LATENCY).
  - resp_last is visible after E(LATENCY+7).
  - resp_valid=0 and req_ready=1 after E(LATENCY+8).
- A new request is accepted no earlier than edge E(LATENCY+8).
- Each stall cycle during BURST extends every later event by one cycle.
- req_ready is decoded from state and is low throughout WAIT and BURST.

## Configuration
- CRITICAL_WORD_FIRST_EN:
  - When defined, start_ofst = req_addr[4:2] latched at acceptance. Beats wrap 7→0, and the last beat has offset start_ofst-1.
  - When undefined, start_ofst=0 and beats always run 0..7.
- Beat count, latency and resp_last timing are identical in both builds.

## Structure
- Shared package holds:
  - LINE_WORDS=8 and OFST_W=3.
  - The responder state typedef (IDLE/WAIT/BURST).
  - The line-base/offset address-split constants, so the cache and responder agree on bit fields [31:5]/[4:2].
- One sub-module, refill_mem_array:
  - MEM_WORDS×32 storage.
  - One synchronous read port and one synchronous write port.
  - Old-data-on-collision read semantics.
- The responder FSM, counters and output registers live in ic_refill_responder.

## Test plan
- Reset release, LATENCY=4, preload mem[0x40..0x47]=0xA0..0xA7, request 0x00000100 at E0 → beats offsets 0..7 with data 0xA0..0xA7 after E4..E11; resp_last only with 0xA7; req_ready=1 after E12.
- Same request with stall=1 for 3 cycles on the third beat → beat offset 2 held for 3 extra cycles, no beat dropped or duplicated, last beat after E14.
- CRITICAL_WORD_FIRST_EN build, request 0x00000114 → offsets 5,6,7,0,1,2,3,4; resp_last with offset 4.
- wr_en to word 0x43 with 0xDEAD on the same edge that registers beat 3 → beat shows 0xA3; a second request returns 0xDEAD at offset 3.
- reset pulled low mid-BURST after beat 2 → outputs return to reset values asynchronously; next request returns a full 8-beat line.
- req_valid held high during BURST, addr 0x200 → ignored until IDLE, then accepted one edge after req_ready rises.

Source files
------------

// File: rtl/ic_refill_responder_pkg.sv
// Shared definitions for the I-cache refill path: line geometry, address split and responder states.
package ic_refill_responder_pkg;

  localparam int LINE_WORDS  = 8;
  localparam int OFST_W      = 3;

  // Byte address split: line base in [31:5], word offset in [4:2].
  localparam int OFST_LSB    = 2;
  localparam int LINE_LSB    = OFST_LSB + OFST_W;
  localparam int LINE_BASE_W = 32 - LINE_LSB;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/ic_refill_responder_mem.sv
// Backing word store for the refill responder: one registered read port, one write port.
// A read and write to the same word on the same edge returns the pre-write word.
module refill_mem_array #(
  parameter int MEM_WORDS = 4096,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] rd_data_q, rd_data_d;

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ic_refill_responder.sv
// Instruction-cache line refill responder: fixed-latency, 8-beat line return with stall hold.
// Optional build macro CRITICAL_WORD_FIRST_EN starts the burst at the requested word.
module ic_refill_responder
  import ic_refill_responder_pkg::*;
#(
  parameter int MEM_WORDS  = 4096,
  parameter int LATENCY    = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [2:0]  resp_ofst,
  output logic        resp_last,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int AW = $clog2(MEM_WORDS);

  rsp_state_e             state_q, state_d;
  logic [3:0]             lat_cnt_q, lat_cnt_d;
  logic [OFST_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [OFST_W-1:0]      resp_ofst_q, resp_ofst_d;
  logic [LINE_BASE_W-1:0] line_base_q, line_base_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_last_q, resp_last_d;
  logic                   beat_fire;
  logic [OFST_W-1:0]      start_ofst;
  logic [OFST_W-1:0]      beat_ofst;
  logic [AW-1:0]          rd_addr;
  logic [AW-1:0]          wr_word;
  logic                   unused_addr_bits;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [OFST_W-1:0] start_ofst_q, start_ofst_d;

  always_comb begin
    start_ofst_d = start_ofst_q;
    if (state_q == S_IDLE && req_valid) start_ofst_d = req_addr[OFST_LSB +: OFST_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) start_ofst_q <= '0;
    else        start_ofst_q <= start_ofst_d;
  end

  assign start_ofst = start_ofst_q;
`else
  assign start_ofst = '0;
`endif

  // Word index wraps inside the line, then the whole index aliases modulo MEM_WORDS.
  assign beat_ofst        = start_ofst + beat_cnt_q;
  assign rd_addr          = AW'({line_base_q, beat_ofst});
  assign wr_word          = AW'(wr_addr[31:OFST_LSB]);
  assign unused_addr_bits = ^{req_addr[LINE_LSB-1:0], wr_addr[OFST_LSB-1:0]};

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    line_base_d  = line_base_q;
    resp_valid_d = resp_valid_q;
    resp_last_d  = resp_last_q;
    resp_ofst_d  = resp_ofst_q;
    beat_fire    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          line_base_d = req_addr[31:LINE_LSB];
          lat_cnt_d   = 4'(LATENCY - 1);
          beat_cnt_d  = '0;
          state_d     = S_WAIT;
        end
      end
      // The edge that sees the count expire already registers beat 0.
      S_WAIT: begin
        if (lat_cnt_q != 4'd0) begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end else if (!stall) begin
          beat_fire = 1'b1;
          state_d   = S_BURST;
        end
      end
      S_BURST: begin
        if (!stall) begin
          if (resp_last_q) begin
            resp_valid_d = 1'b0;
            resp_last_d  = 1'b0;
            state_d      = S_IDLE;
          end else begin
            beat_fire = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (beat_fire) begin
      resp_valid_d = 1'b1;
      resp_ofst_d  = beat_ofst;
      resp_last_d  = (beat_cnt_q == OFST_W'(LINE_WORDS - 1));
      beat_cnt_d   = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      line_base_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_ofst_q  <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      line_base_q  <= line_base_d;
      resp_valid_q <= resp_valid_d;
      resp_last_q  <= resp_last_d;
      resp_ofst_q  <= resp_ofst_d;
    end
  end

  refill_mem_array #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (reset),
    .rd_en   (beat_fire),
    .rd_addr (rd_addr),
    .rd_data (resp_data),
    .wr_en   (wr_en),
    .wr_addr (wr_word),
    .wr_data (wr_data)
  );

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_ofst  = resp_ofst_q;
  assign resp_last  = resp_last_q;

endmodule

// File: tb/tb_ic_refill_responder.sv
// Directed scoreboard bench for ic_refill_responder: expected beats (data, offset, last, edge) are
// queued at request acceptance and checked as the responder emits them.
module tb_ic_refill_responder;

  localparam int LAT  = 4;
  localparam int MEMW = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [2:0]  resp_ofst;
  logic        resp_last;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  ic_refill_responder #(.MEM_WORDS(MEMW), .LATENCY(LAT), .LINE_WORDS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ofst  (resp_ofst),
    .resp_last  (resp_last),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  ofst;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] mdl [int];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] held_data = '0;
  logic [2:0]  held_ofst = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Beat monitor: a beat is new when stall was low at the edge, otherwise it must be held.
  always @(posedge clk) begin
    logic  s;
    beat_t e;
    s = stall;
    #1;
    if (resp_valid) begin
      if (s) begin
        chk("hold_ofst", 32'(resp_ofst), 32'(held_ofst));
        chk("hold_data", resp_data, held_data);
      end else if (sb.size() == 0) begin
        chk("unexpected_beat", 32'(resp_ofst), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("beat_data", resp_data, e.data);
        chk("beat_ofst", 32'(resp_ofst), 32'(e.ofst));
        chk("beat_last", 32'(resp_last), 32'(e.last));
        chk("beat_cycle", 32'(cyc), 32'(e.cyc));
        held_data = resp_data;
        held_ofst = resp_ofst;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a, input logic [2:0] o);
    return int'((((a >> 5) << 3) | 32'(o)) & 32'(MEMW - 1));
  endfunction

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    mdl[int'((a >> 2) & 32'(MEMW - 1))] = d;
  endtask

  task automatic accept(input logic [31:0] a, output int e0);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
    e0 = cyc;
    chk("req_ready_busy", 32'(req_ready), 32'd0);
  endtask

  // Beats after index stall_after are delayed by stall_len edges.
  task automatic push_line(input logic [31:0] a, input int e0, input int stall_after, input int stall_len);
    beat_t      e;
    logic [2:0] start;
    logic [2:0] o;
`ifdef CRITICAL_WORD_FIRST_EN
    start = a[4:2];
`else
    start = 3'd0;
`endif
    for (int k = 0; k < 8; k++) begin
      o      = start + 3'(k);
      e.data = mdl[widx(a, o)];
      e.ofst = o;
      e.last = (k == 7);
      e.cyc  = e0 + LAT + k + ((k > stall_after) ? stall_len : 0);
      sb.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 100 && cyc < target; i++) tick();
    chk("wait_cycle", 32'(cyc), 32'(target));
  endtask

  task automatic drain(input int ready_cyc);
    for (int i = 0; i < 100 && (sb.size() != 0 || !req_ready); i++) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("ready_cycle", 32'(cyc), 32'(ready_cyc));
  endtask

  initial begin
    int e0;
    int e1;

    // Reset values while held in reset
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_ofst", 32'(resp_ofst), 32'd0);
    chk("rst_resp_last", 32'(resp_last), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      wr_word(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      wr_word(32'h200 + 32'(4 * i), 32'hB0 + 32'(i));
    end

    // Plain refill
    accept(32'h0000_0100, e0);
    push_line(32'h0000_0100, e0, 8, 0);
    drain(e0 + LAT + 8);

    // Three stall cycles on the third beat
    accept(32'h0000_0100, e0);
    push_line(32'h0000_0100, e0, 2, 3);
    wait_cyc(e0 + LAT + 2);
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    drain(e0 + LAT + 8 + 3);

    // Write colliding with the edge that registers beat 3
    accept(32'h0000_0100, e0);
    push_line(32'h0000_0100, e0, 8, 0);
    wait_cyc(e0 + LAT + 2);
    wr_word(32'h0000_010C, 32'h0000_DEAD);
    drain(e0 + LAT + 8);
    accept(32'h0000_0100, e0);
    push_line(32'h0000_0100, e0, 8, 0);
    drain(e0 + LAT + 8);

    // Address aliasing beyond MEM_WORDS
    accept(32'h0000_4100, e0);
    push_line(32'h0000_4100, e0, 8, 0);
    drain(e0 + LAT + 8);

    // Mid-line request address (critical word in the optional build)
    accept(32'h0000_0114, e0);
    push_line(32'h0000_0114, e0, 8, 0);
    drain(e0 + LAT + 8);

    // Request held high during a burst is ignored until idle
    accept(32'h0000_0100, e0);
    push_line(32'h0000_0100, e0, 8, 0);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0200;
    for (int i = 0; i < 100 && !req_ready; i++) tick();
    chk("busy_ready_cycle", 32'(cyc), 32'(e0 + LAT + 8));
    tick();
    req_valid = 1'b0;
    e1 = cyc;
    chk("busy_accept_cycle", 32'(e1), 32'(e0 + LAT + 9));
    chk("busy_accept_ready", 32'(req_ready), 32'd0);
    push_line(32'h0000_0200, e1, 8, 0);
    drain(e1 + LAT + 8);

    // Asynchronous reset after beat 2
    accept(32'h0000_0100, e0);
    push_line(32'h0000_0100, e0, 8, 0);
    wait_cyc(e0 + LAT + 2);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_resp_data", resp_data, 32'd0);
    chk("mid_rst_resp_ofst", 32'(resp_ofst), 32'd0);
    chk("mid_rst_resp_last", 32'(resp_last), 32'd0);
    sb.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    accept(32'h0000_0200, e0);
    push_line(32'h0000_0200, e0, 8, 0);
    drain(e0 + LAT + 8);

    repeat (3) tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
